// File: rtl/aes_key_if.sv
// ---------------------------------------------------------------------------
// aes_key_if
// Bundles the AES-128 key schedule's load/handshake signals.
//   master : upstream/consumer side (drives start, cipher_key, key_ready_in)
//   slave  : the key schedule itself (drives round keys and status)
// Signals:
//   start, cipher_key      load request and 128-bit cipher key
//   key_ready_in           downstream accepts the current round key
//   round_key, round_idx   current round key and its index (0..10)
//   key_valid_out, busy    key valid / schedule in progress
//   done                   one-cycle pulse after the last round key is taken
//   state_dbg              FSM state (0 = IDLE, 1 = GEN)
// Optional (macro AES_KEY_STORE_EN): rd_idx, rd_key, store_vld.
//
// Handshake: a round key transfers on every rising clock edge where
// key_valid_out and key_ready_in are both high; while valid is high and ready
// is low, round_key/round_idx/key_valid_out stay stable.
// ---------------------------------------------------------------------------
interface aes_key_if #(parameter int DATA_W = 128);
  logic              start;
  logic [DATA_W-1:0] cipher_key;
  logic              key_ready_in;
  logic [DATA_W-1:0] round_key;
  logic [3:0]        round_idx;
  logic              key_valid_out;
  logic              busy;
  logic              done;
  logic              state_dbg;
`ifdef AES_KEY_STORE_EN
  logic [3:0]        rd_idx;
  logic [DATA_W-1:0] rd_key;
  logic              store_vld;

  modport master (
    output start, cipher_key, key_ready_in, rd_idx,
    input  round_key, round_idx, key_valid_out, busy, done, state_dbg,
           rd_key, store_vld
  );
  modport slave (
    input  start, cipher_key, key_ready_in, rd_idx,
    output round_key, round_idx, key_valid_out, busy, done, state_dbg,
           rd_key, store_vld
  );
`else
  modport master (
    output start, cipher_key, key_ready_in,
    input  round_key, round_idx, key_valid_out, busy, done, state_dbg
  );
  modport slave (
    input  start, cipher_key, key_ready_in,
    output round_key, round_idx, key_valid_out, busy, done, state_dbg
  );
`endif
endinterface

// File: rtl/aes_key_expansion.sv
// ---------------------------------------------------------------------------
// aes_key_expansion
// Iterative AES-128 key schedule: loads a cipher key on start and emits round
// keys 0..NUM_ROUNDS, one per valid/ready handshake, one new key per cycle.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   kif    aes_key_if.slave (start, cipher_key, key_ready_in in;
//          round_key, round_idx, key_valid_out, busy, done, state_dbg out)
// Optional feature, macro AES_KEY_STORE_EN: 11-entry round-key store written
// on every accepted key, with a registered read port (rd_idx -> rd_key, one
// cycle latency; rd_idx > 10 reads 0) and store_vld (set with done, cleared
// by an accepted start or reset).
// ---------------------------------------------------------------------------
module aes_key_expansion #(
  parameter int DATA_W     = 128,
  parameter int NUM_ROUNDS = 10
) (
  input  logic     clk,
  input  logic     reset,
  aes_key_if.slave kif
);

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_t;

  // FIPS-197 forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] pos;
    pos  = 11'd2047 - {b, 3'b000};
    sbox = SBOX_TABLE[pos -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] round_key_q, round_key_d;
  logic [3:0]        round_idx_q, round_idx_d;
  logic [7:0]        rcon_q, rcon_d;
  logic              done_q, done_d;

  logic              accept_start;
  logic              handshake;
  logic [31:0]       w0, w1, w2, w3, rot, t;
  logic [31:0]       n0, n1, n2, n3;

  assign accept_start = (state_q == IDLE) && kif.start;
  assign handshake    = (state_q == GEN) && kif.key_ready_in;

  // Next round key from the current one.
  always_comb begin
    w0  = round_key_q[127:96];
    w1  = round_key_q[95:64];
    w2  = round_key_q[63:32];
    w3  = round_key_q[31:0];
    rot = {w3[23:0], w3[31:24]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
          ^ {rcon_q, 24'h0};
    n0  = w0 ^ t;
    n1  = w1 ^ n0;
    n2  = w2 ^ n1;
    n3  = w3 ^ n2;
  end

  always_comb begin
    state_d     = state_q;
    round_key_d = round_key_q;
    round_idx_d = round_idx_q;
    rcon_d      = rcon_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          state_d     = GEN;
          round_key_d = kif.cipher_key;
          round_idx_d = 4'd0;
          rcon_d      = 8'h01;
        end
      end
      GEN: begin
        if (kif.key_ready_in) begin
          if (round_idx_q == 4'(NUM_ROUNDS)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            round_key_d = {n0, n1, n2, n3};
            round_idx_d = round_idx_q + 4'd1;
            rcon_d      = xtime(rcon_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_key_q <= '0;
      round_idx_q <= 4'd0;
      rcon_q      <= 8'h01;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_key_q <= round_key_d;
      round_idx_q <= round_idx_d;
      rcon_q      <= rcon_d;
      done_q      <= done_d;
    end
  end

  assign kif.round_key     = round_key_q;
  assign kif.round_idx     = round_idx_q;
  assign kif.key_valid_out = (state_q == GEN);
  assign kif.busy          = (state_q == GEN);
  assign kif.done          = done_q;
  assign kif.state_dbg     = (state_q == GEN);

`ifdef AES_KEY_STORE_EN
  logic [DATA_W-1:0] store_q [11];
  logic [DATA_W-1:0] rd_key_q, rd_key_d;
  logic              store_vld_q, store_vld_d;

  always_comb begin
    rd_key_d = '0;
    if (kif.rd_idx <= 4'(NUM_ROUNDS)) rd_key_d = store_q[kif.rd_idx];
    store_vld_d = store_vld_q;
    if (accept_start) store_vld_d = 1'b0;
    if (done_d)       store_vld_d = 1'b1;
  end

  // Key storage carries no reset; store_vld tells the reader when it is whole.
  always_ff @(posedge clk) begin
    if (!reset && handshake) store_q[round_idx_q] <= round_key_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_key_q    <= '0;
      store_vld_q <= 1'b0;
    end else begin
      rd_key_q    <= rd_key_d;
      store_vld_q <= store_vld_d;
    end
  end

  assign kif.rd_key    = rd_key_q;
  assign kif.store_vld = store_vld_q;
`else
  // Round keys are only streamed; no replay store in this build.
`endif

endmodule

// File: tb/tb_aes_key_expansion.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expansion
// Self-checking bench for aes_key_expansion. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge or 1 ns after a rising
// edge. Expected round keys (FIPS-197 Appendix A.1 schedule) are queued when a
// start is driven and compared as each key is handed off.
// ---------------------------------------------------------------------------
module tb_aes_key_expansion;

  logic clk;
  logic reset;
  aes_key_if #(.DATA_W(128)) kif();

  aes_key_expansion #(.DATA_W(128), .NUM_ROUNDS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  // ---- clock / reset ----
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---- reference data ----
  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] fips_rk [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  // ---- scoreboard ----
  // entry = {check_key, idx[3:0], key[127:0]}
  logic [132:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check_val(input string tag, input logic [127:0] act,
                           input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Monitor: compare every handed-off key against the queue head.
  always @(negedge clk) begin
    logic [132:0] e;
    if (kif.done) done_cnt++;
    if (!reset && kif.key_valid_out && kif.key_ready_in) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_key", 128'(kif.key_valid_out), 128'd0);
      end else begin
        e = exp_q.pop_front();
        check_val($sformatf("r%0d_idx", e[131:128]), 128'(kif.round_idx), 128'(e[131:128]));
        if (e[132]) check_val($sformatf("r%0d_key", e[131:128]), kif.round_key, e[127:0]);
      end
    end
  end

  // ---- driver tasks ----
  task automatic push_fips();
    for (int i = 0; i <= 10; i++) exp_q.push_back({1'b1, 4'(i), fips_rk[i]});
  endtask

  task automatic start_key(input logic [127:0] k);
    kif.cipher_key = k;
    kif.start      = 1'b1;
    @(posedge clk); #1;
    kif.start      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_idx(input logic [3:0] i);
    int n = 0;
    while (!(kif.key_valid_out && kif.round_idx == i) && n < 60) begin
      @(posedge clk); #1; n++;
    end
    check_val("wait_idx", 128'(kif.round_idx), 128'(i));
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!kif.done && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check_val({tag, "_done"}, 128'(kif.done), 128'd1);
  endtask

  // ---- stimulus ----
  initial begin
    reset            = 1'b1;
    kif.start        = 1'b0;
    kif.cipher_key   = '0;
    kif.key_ready_in = 1'b1;
`ifdef AES_KEY_STORE_EN
    kif.rd_idx       = 4'd0;
`endif
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_valid", 128'(kif.key_valid_out), 128'd0);
    check_val("rst_busy",  128'(kif.busy), 128'd0);
    check_val("rst_done",  128'(kif.done), 128'd0);
    check_val("rst_idx",   128'(kif.round_idx), 128'd0);
    check_val("rst_key",   kif.round_key, 128'd0);
    check_val("rst_state", 128'(kif.state_dbg), 128'd0);
`ifdef AES_KEY_STORE_EN
    check_val("rst_rd_key",    kif.rd_key, 128'd0);
    check_val("rst_store_vld", 128'(kif.store_vld), 128'd0);
`endif
    @(posedge clk); #1;
    reset = 1'b0;
    idle(2);

    // Test 1: FIPS key with ready tied high, 11 back-to-back keys.
    push_fips();
    start_key(FIPS_KEY);
    @(negedge clk);
    check_val("t1_first_valid", 128'(kif.key_valid_out), 128'd1);
    check_val("t1_busy", 128'(kif.busy), 128'd1);
    @(posedge clk); #1;
    wait_done("t1");
    idle(2);
    check_val("t1_done_pulses", 128'(done_cnt), 128'd1);
    check_val("t1_idle_valid", 128'(kif.key_valid_out), 128'd0);
    check_val("t1_hold_last", kif.round_key, fips_rk[10]);
    check_val("t1_idle_idx", 128'(kif.round_idx), 128'd10);

`ifdef AES_KEY_STORE_EN
    // Test 6: read back the store.
    check_val("t6_store_vld", 128'(kif.store_vld), 128'd1);
    kif.rd_idx = 4'd10;
    idle(1);
    check_val("t6_rd10", kif.rd_key, fips_rk[10]);
    kif.rd_idx = 4'd12;
    idle(1);
    check_val("t6_rd12", kif.rd_key, 128'd0);
    kif.rd_idx = 4'd3;
    idle(1);
    check_val("t6_rd3", kif.rd_key, fips_rk[3]);
`endif

    // Test 2: stall at idx4 for three cycles.
    push_fips();
    start_key(FIPS_KEY);
`ifdef AES_KEY_STORE_EN
    check_val("t6_store_vld_clr", 128'(kif.store_vld), 128'd0);
`endif
    wait_idx(4'd4);
    kif.key_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("t2_hold%0d_key", i), kif.round_key, fips_rk[4]);
      check_val($sformatf("t2_hold%0d_idx", i), 128'(kif.round_idx), 128'd4);
      check_val($sformatf("t2_hold%0d_vld", i), 128'(kif.key_valid_out), 128'd1);
      @(posedge clk); #1;
    end
    check_val("t2_hold3_key", kif.round_key, fips_rk[4]);
    kif.key_ready_in = 1'b1;
    wait_done("t2");
    idle(2);

    // Test 3: start while busy is ignored.
    push_fips();
    start_key(FIPS_KEY);
    wait_idx(4'd5);
    start_key(128'd0);
    kif.cipher_key = FIPS_KEY;
    check_val("t3_busy", 128'(kif.busy), 128'd1);
    check_val("t3_idx",  128'(kif.round_idx), 128'd6);
    check_val("t3_key",  kif.round_key, fips_rk[6]);
    wait_done("t3");
    idle(2);
    check_val("t3_done_total", 128'(done_cnt), 128'd3);

    // Test 4: reset mid-schedule, then the all-zero key.
    push_fips();
    start_key(FIPS_KEY);
    wait_idx(4'd7);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_val("t4_valid", 128'(kif.key_valid_out), 128'd0);
    check_val("t4_busy",  128'(kif.busy), 128'd0);
    check_val("t4_idx",   128'(kif.round_idx), 128'd0);
    check_val("t4_key",   kif.round_key, 128'd0);
    check_val("t4_state", 128'(kif.state_dbg), 128'd0);
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 4'd0, 128'd0});
    exp_q.push_back({1'b1, 4'd1, 128'h62636363626363636263636362636363});
    for (int i = 2; i <= 10; i++) exp_q.push_back({1'b0, 4'(i), 128'd0});
    start_key(128'd0);
    wait_done("t4");
    idle(2);
    check_val("t4_done_total", 128'(done_cnt), 128'd4);

    // Test 5: start during the done cycle, no gap.
    push_fips();
    start_key(FIPS_KEY);
    wait_done("t5a");
    push_fips();
    start_key(FIPS_KEY);
    @(negedge clk);
    check_val("t5_valid", 128'(kif.key_valid_out), 128'd1);
    check_val("t5_idx",   128'(kif.round_idx), 128'd0);
    @(posedge clk); #1;
    wait_done("t5b");
    idle(3);
    check_val("done_total", 128'(done_cnt), 128'd6);
    check_val("queue_empty", 128'(exp_q.size()), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
